fetch_mem_arbiter: RTL and testbench
====================================

# fetch_mem_arbiter

Arbiter and sequencer for a single-port, fixed-latency unified instruction/data memory shared between the fetch stage and the load/store (MEM) stage of the 5-stage pipeline. It grants one access at a time, times the memory latency, returns read data with a one-cycle valid pulse, and produces stall signals that drive the fetch stage's PC_write low and hold the MEM stage. A taken branch (PCSrc) squashes any fetch still in flight.

## Interface
- MEM_LATENCY, 2: cycles from memory enable to read-data capture; legal range 1..15.
- STARVE_MAX, 4: consecutive data grants allowed while a fetch waits; used only with starvation guard.
- clk  in  1  pipeline clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request, level; held until if_valid.
- if_addr  in  32  fetch byte address; bits [11:2] used.
- flush  in  1  PCSrc; taken branch, squashes pending/in-flight fetch.
- if_rdata  out  32  fetched instruction.
- if_valid  out  1  one-cycle pulse, if_rdata valid.
- stall_if  out  1  if_req & ~if_valid; fetch stage uses PC_write = ~stall_if.
- dm_req  in  1  data request, level; held until dm_valid.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  32  data byte address; bits [11:2] used.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data (undefined for stores).
- dm_valid  out  1  one-cycle pulse, access complete.
- stall_mem  out  1  dm_req & ~dm_valid.
- mem_en  out  1  memory access strobe, one cycle per access.
- mem_we  out  1  write enable, qualified by mem_en.
- mem_addr  out  10  word address.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  memory read data, valid MEM_LATENCY cycles after mem_en.

## Operation
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE, at posedge: if dm_req and grant policy favours data -> BUSY_DM; else if if_req & ~flush -> BUSY_IF; else stay. Requests sampled only in IDLE.
- Grant edge: mem_en=1 for the next cycle only; mem_addr/mem_we/mem_wdata registered from the granted port (mem_we=0 for fetch); cnt loaded MEM_LATENCY-1.
- BUSY_x: cnt decrements each edge; at the edge where cnt==0: capture mem_rdata into x_rdata, pulse x_valid for one cycle, return to IDLE.
- Requester must deassert x_req in the x_valid cycle unless issuing a new access; a req still high at the following IDLE edge is a new request.
- Flush: in BUSY_IF sets drop flag; memory access completes, but if_valid is suppressed and if_rdata unchanged. Flush coincident with IF completion edge also suppresses. Flush in BUSY_DM or IDLE without pending fetch: no effect. Drop flag clears on return to IDLE.
- Policy: data wins ties (older instruction).
- Reset (any state): state IDLE, cnt 0, drop 0, starve counter 0, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, if_valid 0, dm_valid 0, if_rdata 0, dm_rdata 0; in-flight access discarded.

## Timing
- Grant at edge E0; mem_en high E0..E1; rdata captured at edge E0+MEM_LATENCY; valid high during the following cycle.
- Access throughput: one per MEM_LATENCY+1 cycles (completion edge returns to IDLE; next grant next edge).
- stall_if/stall_mem combinational from req and registered valid; no other combinational input-to-output paths.

## Configuration
- FETCH_ARB_STARVE_GUARD_EN defined: starve counter counts consecutive data grants made while if_req & ~flush; when it equals STARVE_MAX and both request in IDLE, fetch is granted and the counter clears; counter also clears on any fetch grant or when if_req is low.
- Undefined: strict data priority; fetch may starve indefinitely; STARVE_MAX ignored, no counter logic.

## Structure
- Package fetch_arb_pkg: state encoding (IDLE=2'd0, BUSY_IF=2'd1, BUSY_DM=2'd2), MEM_AW=10, word-address slice constants.
- One sub-module: mem_latency_timer (load, decrement, done flag), instanced once.

## Test plan
- MEM_LATENCY=2, if_req only, if_addr=0x10, mem_rdata=0xDEADBEEF -> mem_addr=4, mem_en one cycle, if_valid pulses 2 cycles after grant edge with if_rdata=0xDEADBEEF; stall_if high until then.
- if_req and dm_req asserted together, dm_we=1, dm_addr=0x20, dm_wdata=0x55 -> data granted first (mem_we=1, mem_addr=8), fetch granted at the edge after dm_valid.
- flush asserted one cycle after fetch grant -> mem access completes, if_valid never pulses, state back to IDLE after MEM_LATENCY edges.
- With FETCH_ARB_STARVE_GUARD_EN, STARVE_MAX=4, dm_req and if_req continuously high -> grant sequence DM,DM,DM,DM,IF repeating; without macro -> DM only.
- reset low during BUSY_DM -> next cycle state IDLE, all outputs zero, no dm_valid pulse.
- MEM_LATENCY=1 back-to-back fetches -> one if_valid every 2 cycles.

Source files
------------

// File: rtl/fetch_arb_pkg.sv
// Shared definitions for the fetch/data memory arbiter: state encoding,
// memory word-address width and the byte-address slice that forms it.
package fetch_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_e;

    localparam int MEM_AW    = 10;
    localparam int WADDR_LSB = 2;
    localparam int WADDR_MSB = WADDR_LSB + MEM_AW - 1;
    localparam int CNT_W     = 4;

endpackage

// File: rtl/mem_latency_timer.sv
// Countdown timer for the fixed memory latency: loaded on a grant, decremented
// while an access is in flight; done marks the completion edge.
module mem_latency_timer
    import fetch_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Arbiter/sequencer sharing one fixed-latency memory between fetch and MEM stages.
// Define FETCH_ARB_STARVE_GUARD_EN to bound consecutive data grants while fetch waits.
module fetch_mem_arbiter
    import fetch_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 2,
    parameter int STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    input  logic              flush,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              stall_if,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic [31:0]       dm_rdata,
    output logic              dm_valid,
    output logic              stall_mem,
    output logic              mem_en,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);

    arb_state_e        state_q;
    logic              drop_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       dm_rdata_q;
    logic              if_valid_q;
    logic              dm_valid_q;

    logic              fetch_want;
    logic              grant_dm;
    logic              grant_if;
    logic              timer_load;
    logic              timer_done;
    logic              unused_ok;

    assign fetch_want = if_req & ~flush;

`ifdef FETCH_ARB_STARVE_GUARD_EN
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] starve_q;
    logic [7:0] starve_d;
    logic       favour_if;

    assign favour_if = fetch_want && (starve_q == STARVE_LIM);
    assign grant_dm  = dm_req & ~favour_if;

    // Counts data grants that overtook a live fetch; never exceeds the limit
    // because reaching it forces the next contended grant to fetch.
    always_comb begin
        starve_d = starve_q;
        if (!if_req) begin
            starve_d = '0;
        end else if (state_q == IDLE) begin
            if (grant_if) begin
                starve_d = '0;
            end else if (grant_dm && fetch_want) begin
                starve_d = starve_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign unused_ok = ^{if_addr[31:WADDR_MSB+1], if_addr[WADDR_LSB-1:0],
                         dm_addr[31:WADDR_MSB+1], dm_addr[WADDR_LSB-1:0]};
`else
    assign grant_dm  = dm_req;
    assign unused_ok = ^{if_addr[31:WADDR_MSB+1], if_addr[WADDR_LSB-1:0],
                         dm_addr[31:WADDR_MSB+1], dm_addr[WADDR_LSB-1:0],
                         STARVE_MAX[0]};
`endif

    assign grant_if   = fetch_want & ~grant_dm;
    assign timer_load = (state_q == IDLE) & (grant_dm | grant_if);

    mem_latency_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (timer_load),
        .load_val_i (LAT_LOAD),
        .dec_i      (state_q != IDLE),
        .done_o     (timer_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            drop_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            mem_en_q   <= 1'b0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    drop_q <= 1'b0;
                    if (grant_dm) begin
                        state_q     <= BUSY_DM;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= dm_we;
                        mem_addr_q  <= dm_addr[WADDR_MSB:WADDR_LSB];
                        mem_wdata_q <= dm_wdata;
                    end else if (grant_if) begin
                        state_q     <= BUSY_IF;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= if_addr[WADDR_MSB:WADDR_LSB];
                        mem_wdata_q <= '0;
                    end
                end
                BUSY_IF: begin
                    // A squashed fetch still runs to completion so the memory
                    // sees a well-formed access; only the result is discarded.
                    if (timer_done) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                        if (!(drop_q || flush)) begin
                            if_rdata_q <= mem_rdata;
                            if_valid_q <= 1'b1;
                        end
                    end else begin
                        drop_q <= drop_q | flush;
                    end
                end
                BUSY_DM: begin
                    if (timer_done) begin
                        state_q    <= IDLE;
                        dm_rdata_q <= mem_rdata;
                        dm_valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_valid  = dm_valid_q;
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter with a latency-exact memory model and
// scoreboard queues popped on each valid pulse.
`timescale 1ns/1ps
module tb_fetch_mem_arbiter;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        flush;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        stall_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_valid;
    logic        stall_mem;
    logic        mem_en;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    fetch_mem_arbiter #(.MEM_LATENCY(L), .STARVE_MAX(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .flush     (flush),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .stall_if  (stall_if),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .stall_mem (stall_mem),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    typedef struct packed {
        logic        chk;
        logic [31:0] data;
    } sb_t;

    int          vectors = 0;
    int          errors  = 0;
    sb_t         if_q[$];
    sb_t         dm_q[$];
    logic [31:0] model [1024];
    int          age      = 255;
    logic [9:0]  lat_addr = '0;
    logic        prev_en  = 1'b0;

    function automatic logic [31:0] mem_word(input int a);
        return 32'hDEADBEEF ^ 32'(a) ^ 32'd4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input bit dm, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (((dm ? dm_valid : if_valid) !== 1'b1) && cyc < 40);
    endtask

    // Memory: read data is only defined on the cycle MEM_LATENCY after mem_en.
    always @(posedge clk) begin
        #1;
        if (mem_en === 1'b1) begin
            age      = 0;
            lat_addr = mem_addr;
            if (mem_we === 1'b1) model[mem_addr] = mem_wdata;
        end else if (age < 255) begin
            age++;
        end
        mem_rdata = (age == L - 1) ? model[lat_addr] : 'x;
    end

    always @(negedge clk) begin
        sb_t e;
        if (mem_en === 1'b1) check("mem_en_single", 32'(prev_en), 32'd0);
        prev_en = (mem_en === 1'b1);
        if (if_valid === 1'b1) begin
            check("if_sb_entry", 32'(if_q.size() > 0), 32'd1);
            if (if_q.size() > 0) begin
                e = if_q.pop_front();
                check("if_rdata", if_rdata, e.data);
            end
        end
        if (dm_valid === 1'b1) begin
            check("dm_sb_entry", 32'(dm_q.size() > 0), 32'd1);
            if (dm_q.size() > 0) begin
                e = dm_q.pop_front();
                if (e.chk) check("dm_rdata", dm_rdata, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int grants;
        bit exp_if;

        reset = 1'b0; if_req = 1'b0; if_addr = '0; flush = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        for (int i = 0; i < 1024; i++) model[i] = mem_word(i);

        repeat (3) @(negedge clk);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_dm_valid", dm_valid, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        check("rst_stall_if", stall_if, 0);
        check("rst_stall_mem", stall_mem, 0);
        reset = 1'b1;

        // Single fetch from 0x10
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        if_q.push_back('{chk: 1'b1, data: 32'hDEADBEEF});
        @(negedge clk);
        check("f_mem_en", mem_en, 1);
        check("f_mem_addr", mem_addr, 4);
        check("f_mem_we", mem_we, 0);
        check("f_stall_if", stall_if, 1);
        @(negedge clk);
        check("f_mem_en_off", mem_en, 0);
        check("f_if_valid_early", if_valid, 0);
        check("f_stall_if2", stall_if, 1);
        @(negedge clk);
        check("f_if_valid", if_valid, 1);
        check("f_stall_if_rel", stall_if, 0);
        if_req = 1'b0;
        @(negedge clk);
        check("f_if_valid_pulse", if_valid, 0);

        // Simultaneous store and fetch: data first, fetch right after dm_valid
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h55;
        dm_q.push_back('{chk: 1'b0, data: 32'h0});
        if_q.push_back('{chk: 1'b1, data: mem_word(16)});
        @(negedge clk);
        check("s_mem_en", mem_en, 1);
        check("s_mem_we", mem_we, 1);
        check("s_mem_addr", mem_addr, 8);
        check("s_mem_wdata", mem_wdata, 32'h55);
        check("s_stall_if", stall_if, 1);
        check("s_stall_mem", stall_mem, 1);
        wait_valid(1'b1, cyc);
        check("s_dm_latency", cyc, L);
        dm_req = 1'b0;
        @(negedge clk);
        check("s_if_grant", mem_en, 1);
        check("s_if_we", mem_we, 0);
        check("s_if_addr", mem_addr, 16);
        wait_valid(1'b0, cyc);
        check("s_if_latency", cyc, L);
        if_req = 1'b0;

        // Load back the stored word
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        dm_q.push_back('{chk: 1'b1, data: 32'h55});
        @(negedge clk);
        check("l_mem_en", mem_en, 1);
        check("l_mem_addr", mem_addr, 8);
        check("l_stall_mem", stall_mem, 1);
        wait_valid(1'b1, cyc);
        check("l_latency", cyc, L);
        check("l_stall_mem_rel", stall_mem, 0);
        dm_req = 1'b0;

        // Flush one cycle after fetch grant
        if_req = 1'b1; if_addr = 32'h80;
        @(negedge clk);
        check("fl_mem_en", mem_en, 1);
        check("fl_mem_addr", mem_addr, 32);
        flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        check("fl_no_valid1", if_valid, 0);
        @(negedge clk);
        check("fl_no_valid2", if_valid, 0);
        check("fl_mem_en_off", mem_en, 0);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        dm_q.push_back('{chk: 1'b1, data: 32'h55});
        @(negedge clk);
        check("fl_idle_grant", mem_en, 1);
        check("fl_idle_addr", mem_addr, 8);
        wait_valid(1'b1, cyc);
        check("fl_dm_latency", cyc, L);
        dm_req = 1'b0;

        // Flush coincident with the fetch completion edge
        if_req = 1'b1; if_addr = 32'h84;
        @(negedge clk);
        check("flc_mem_en", mem_en, 1);
        @(negedge clk);
        flush = 1'b1; if_req = 1'b0;
        @(negedge clk);
        check("flc_no_valid", if_valid, 0);
        flush = 1'b0;
        @(negedge clk);
        check("flc_no_valid2", if_valid, 0);
        check("flc_if_rdata_hold", if_rdata, mem_word(16));

        // Both requesters held high continuously
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h10;
        grants = 0; cyc = 0;
        while (grants < 10 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mem_en === 1'b1) begin
`ifdef FETCH_ARB_STARVE_GUARD_EN
                exp_if = ((grants % 5) == 4);
`else
                exp_if = 1'b0;
`endif
                check("starve_grant_addr", mem_addr, exp_if ? 32'd4 : 32'd8);
                if (exp_if) if_q.push_back('{chk: 1'b1, data: 32'hDEADBEEF});
                else        dm_q.push_back('{chk: 1'b1, data: 32'h55});
                grants++;
            end
        end
        check("starve_grant_count", grants, 10);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(if_valid === 1'b1 || dm_valid === 1'b1) && cyc < 40);
        check("starve_final_valid", 32'(cyc < 40), 32'd1);
        dm_req = 1'b0; if_req = 1'b0;

        // Reset while a data access is in flight
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
        @(negedge clk);
        check("r_grant", mem_en, 1);
        reset = 1'b0;
        @(negedge clk);
        check("r_mem_en", mem_en, 0);
        check("r_mem_we", mem_we, 0);
        check("r_mem_addr", mem_addr, 0);
        check("r_mem_wdata", mem_wdata, 0);
        check("r_dm_valid", dm_valid, 0);
        check("r_dm_rdata", dm_rdata, 0);
        check("r_if_rdata", if_rdata, 0);
        check("r_if_valid", if_valid, 0);
        dm_req = 1'b0; reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("r_no_dm_valid", dm_valid, 0);
        end

        check("sb_if_empty", 32'(if_q.size()), 0);
        check("sb_dm_empty", 32'(dm_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
